// File: rtl/chip8_pkg.sv
// Shared types and constants for the Chip-8 unified memory: address/byte types,
// memory geometry and the built-in hexadecimal font table.
package chip8_pkg;

  localparam int MEM_DEPTH  = 4096;
  localparam int FONT_BYTES = 80;

  typedef logic [11:0] addr_t;
  typedef logic [7:0]  byte_t;

  localparam addr_t FONT_BASE = 12'h050;

  // Glyph n occupies FONT[5n .. 5n+4], one byte per pixel row, MSB = leftmost pixel
  localparam byte_t FONT [FONT_BYTES] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  // 0
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,  // 1
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  // 2
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,  // 3
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  // 4
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,  // 5
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  // 6
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,  // 7
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  // 8
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,  // 9
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  // A
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,  // B
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  // C
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,  // D
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  // E
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80   // F
  };

endpackage

// File: rtl/chip8_font_rom.sv
// Combinational font lookup: byte index 0..79 into the built-in hex font.
// Compiled only when CHIP8_FONT_ROM_EN is defined.
`ifdef CHIP8_FONT_ROM_EN
module chip8_font_rom
  import chip8_pkg::*;
(
  input  logic [6:0] idx_i,
  output byte_t      byte_o
);

  always_comb begin
    byte_o = '0;
    if (int'(idx_i) < FONT_BYTES) byte_o = FONT[idx_i];
  end

endmodule
`endif

// File: rtl/chip8_memory.sv
// Chip-8 unified 4 KiB RAM: combinational read, synchronous write, rst-priority.
// Macro CHIP8_FONT_ROM_EN enables font preload at power-up and reload on rst.
module chip8_memory
  import chip8_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              set,
  output logic [DATA_W-1:0] data_out
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] mem_t [DEPTH];

  // Power-up image: zeros everywhere, font in place when the ROM is enabled
  function automatic mem_t mem_init();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = '0;
`ifdef CHIP8_FONT_ROM_EN
    for (int i = 0; i < FONT_BYTES; i++) m[int'(FONT_BASE) + i] = FONT[i];
`endif
    return m;
  endfunction

  mem_t mem_q = mem_init();

`ifdef CHIP8_FONT_ROM_EN
  logic [DATA_W-1:0] font_w [FONT_BYTES];

  for (genvar g = 0; g < FONT_BYTES; g++) begin : g_font
    chip8_font_rom u_font_rom (
      .idx_i  (7'(g)),
      .byte_o (font_w[g])
    );
  end
`endif

  // rst wins over set; a write presented during reset is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef CHIP8_FONT_ROM_EN
      for (int i = 0; i < FONT_BYTES; i++) begin
        mem_q[ADDR_W'(int'(FONT_BASE) + i)] <= font_w[i];
      end
`endif
    end else if (set) begin
      mem_q[address] <= data_in;
    end
  end

  assign data_out = mem_q[address];

endmodule

// File: tb/tb_chip8_memory.sv
// Directed self-checking bench for chip8_memory; expectations follow the
// CHIP8_FONT_ROM_EN setting of the build.
module tb_chip8_memory;

`ifdef CHIP8_FONT_ROM_EN
  localparam bit FONT_EN = 1'b1;
`else
  localparam bit FONT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] address = '0;
  logic [7:0]  data_in = '0;
  logic        set = 1'b0;
  logic [7:0]  data_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_d0 [5];
  logic [7:0] exp_d1 [5];
  logic [7:0] exp_d9 [5];
  logic [7:0] exp_df [5];

  chip8_memory #(.ADDR_W(12), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .data_in  (data_in),
    .set      (set),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] expv);
    checks++;
    assert (data_out === expv)
      else begin
        errors++;
        $error("FAIL %s: observed %02h expected %02h", tag, data_out, expv);
      end
  endtask

  task automatic rd(input logic [11:0] a, input string tag, input logic [7:0] expv);
    address = a;
    #1;
    check(tag, expv);
  endtask

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a;
    data_in = d;
    set = 1'b1;
    @(posedge clk);
    #1;
    set = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    exp_d0 = '{8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0};
    exp_d1 = '{8'h20, 8'h60, 8'h20, 8'h20, 8'h70};
    exp_d9 = '{8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0};
    exp_df = '{8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80};

    // Power-up contents
    #2;
    rd(12'h050, "pwrup_050", FONT_EN ? 8'hF0 : 8'h00);
    rd(12'h001, "pwrup_001", 8'h00);
    rd(12'h200, "pwrup_200", 8'h00);

    pulse_rst();
    for (int i = 0; i < 5; i++) begin
      rd(12'h050 + 12'(i), "font_d0", FONT_EN ? exp_d0[i] : 8'h00);
      rd(12'h055 + 12'(i), "font_d1", FONT_EN ? exp_d1[i] : 8'h00);
      rd(12'h07D + 12'(i), "font_d9", FONT_EN ? exp_d9[i] : 8'h00);
      rd(12'h09B + 12'(i), "font_df", FONT_EN ? exp_df[i] : 8'h00);
    end
    rd(12'h04F, "below_font", 8'h00);
    rd(12'h0A0, "above_font", 8'h00);

    // Basic write / hold
    wr(12'h001, 8'hA5);
    check("wr_001", 8'hA5);
    @(posedge clk); #1;
    check("hold_001", 8'hA5);

    wr(12'h002, 8'h3C);
    check("wr_002", 8'h3C);
    rd(12'h001, "keep_001", 8'hA5);

    // Read-during-write to the same address
    @(negedge clk);
    address = 12'h003;
    data_in = 8'h5A;
    set = 1'b1;
    #1;
    check("rdw_before", 8'h00);
    @(posedge clk); #1;
    set = 1'b0;
    check("rdw_after", 8'h5A);

    // Overwrite font byte, then reset reload
    wr(12'h050, 8'h11);
    check("wr_050", 8'h11);
    pulse_rst();
    rd(12'h050, "reload_050", FONT_EN ? 8'hF0 : 8'h11);
    rd(12'h001, "rst_keep_001", 8'hA5);
    rd(12'h003, "rst_keep_003", 8'h5A);

    // rst and set together: write dropped, next cycle resumes
    @(negedge clk);
    address = 12'h200;
    data_in = 8'h77;
    set = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set = 1'b0;
    check("rst_drops_wr", 8'h00);
    wr(12'h200, 8'h78);
    check("resume_wr", 8'h78);

    // Back-to-back writes, set held high across edges
    @(negedge clk);
    set = 1'b1;
    address = 12'h300;
    data_in = 8'hC1;
    @(negedge clk);
    address = 12'h301;
    data_in = 8'hC2;
    @(negedge clk);
    address = 12'h310;
    data_in = 8'h01;
    @(negedge clk);
    data_in = 8'h02;
    @(posedge clk); #1;
    set = 1'b0;
    check("last_wins_310", 8'h02);
    rd(12'h300, "b2b_300", 8'hC1);
    rd(12'h301, "b2b_301", 8'hC2);

    // Edge addresses, no wrap
    wr(12'hFFF, 8'hFF);
    wr(12'h000, 8'h01);
    rd(12'hFFF, "edge_fff", 8'hFF);
    rd(12'h000, "edge_000", 8'h01);
    rd(12'h7FF, "no_alias_7ff", 8'h00);
    rd(12'h001, "final_001", 8'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
